ifetch_group: RTL and testbench

//  Multi-line fetch unit between the PC unit, the icache and decode.
//  - Fetches an aligned group of FETCH_WIDTH instructions per request, one request outstanding.
//  - Buffers returned groups in a queue of IFQ_DEPTH entries.
//  - Presents groups to decode under a valid/ready handshake.
//  - Discards in-flight and queued work on flush.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/ifetch_queue.sv | 68 ++++++
 rtl/ifetch_group.sv | 148 ++++++++++++++
 tb/tb_ifetch_group.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the multi-line instruction fetch unit.
// Default geometry lives here; ifetch_group derives its own entry layout from its parameters.
package ifetch_pkg;

  localparam int INSTR_W         = 32;
  localparam int XLEN_DEF        = 32;
  localparam int FETCH_WIDTH_DEF = 2;
  localparam int IFQ_DEPTH_DEF   = 4;
  localparam int OFF_W           = $clog2(FETCH_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0]                      pc_base;
    logic [FETCH_WIDTH_DEF-1:0]               valid_mask;
    logic [FETCH_WIDTH_DEF-1:0][INSTR_W-1:0]  instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Power-of-two FIFO of fetch groups with push/pop/flush; pointers wrap naturally.
// Push on full and pop on empty are ignored; flush clears occupancy on the next edge.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter type entry_t = ifq_entry_t,
  parameter int  DEPTH   = IFQ_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  entry_t                    push_data_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  output entry_t                    head_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign do_push = push_i & (count_q != CNT_W'(DEPTH)) & ~flush_i;
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_group.sv
// Fetch unit: one outstanding icache request per aligned group, queued towards decode.
// Optional IFETCH_PERF_EN adds saturating stall and flush cycle counters.
module ifetch_group
  import ifetch_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int IFQ_DEPTH   = IFQ_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pc_v_i,
  input  logic [XLEN-1:0]               pc_i,
  output logic                          pc_ready_o,
  input  logic                          flush_i,
  output logic                          icache_req_o,
  output logic [XLEN-1:0]               icache_adr_o,
  input  logic                          icache_stall_i,
  input  logic [INSTR_W*FETCH_WIDTH-1:0] icache_instr_i,
  output logic [FETCH_WIDTH-1:0]        dec_valid_o,
  output logic [INSTR_W*FETCH_WIDTH-1:0] dec_instr_o,
  output logic [XLEN*FETCH_WIDTH-1:0]   dec_pc_o,
  input  logic                          dec_ready_i
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt_o,
  output logic [31:0]                   perf_flush_cnt_o
`endif
);

  localparam int CNT_W = $clog2(IFQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]                      pc_base;
    logic [FETCH_WIDTH-1:0]               valid_mask;
    logic [FETCH_WIDTH-1:0][INSTR_W-1:0]  instr;
  } grp_t;

  ifetch_state_e    state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  grp_adr, grp_off;
  logic             accept, push, pop, q_empty;
  logic [CNT_W-1:0] q_count;
  grp_t             push_grp, head_grp;

  assign grp_adr = pc_q & ~XLEN'(FETCH_WIDTH * 4 - 1);
  assign grp_off = (pc_q >> 2) & XLEN'(FETCH_WIDTH - 1);

  // The in-flight request already owns a queue slot, so a push can never overflow.
  // Gating with reset keeps every output low while reset is held.
  assign pc_ready_o = ~reset & ~flush_i & (state_q != DROP)
                    & ((state_q == IDLE) | ~icache_stall_i)
                    & ((int'(q_count) + int'(state_q == WAIT)) < IFQ_DEPTH);
  assign accept     = pc_v_i & pc_ready_o;
  assign push       = (state_q == WAIT) & ~icache_stall_i & ~flush_i;
  assign pop        = dec_ready_i & (|dec_valid_o);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (accept) pc_d = pc_i;
    unique case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (flush_i)              state_d = icache_stall_i ? DROP : IDLE;
        else if (!icache_stall_i) state_d = accept ? WAIT : IDLE;
      end
      DROP: if (!icache_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign icache_req_o = (state_q != IDLE);
  assign icache_adr_o = icache_req_o ? grp_adr : '0;

  always_comb begin
    push_grp.pc_base = grp_adr;
    push_grp.instr   = icache_instr_i;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      push_grp.valid_mask[k] = (XLEN'(k) >= grp_off);
    end
  end

  ifetch_queue #(
    .entry_t (grp_t),
    .DEPTH   (IFQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_grp),
    .pop_i       (pop),
    .flush_i     (flush_i),
    .head_o      (head_grp),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  // Lines before the entry offset present zero instruction and zero PC.
  always_comb begin
    dec_valid_o = '0;
    dec_instr_o = '0;
    dec_pc_o    = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (!q_empty && head_grp.valid_mask[k]) begin
        dec_valid_o[k]                 = 1'b1;
        dec_instr_o[k*INSTR_W +: INSTR_W] = head_grp.instr[k];
        dec_pc_o[k*XLEN +: XLEN]       = head_grp.pc_base + XLEN'(4 * k);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != IDLE) && icache_stall_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_i && (flush_cnt_q != '1))                               flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_group.sv
// Directed bench for ifetch_group (FETCH_WIDTH=2, IFQ_DEPTH=4): vector table plus
// hand-written multi-cycle sequences checked against an expected-group queue.
module tb_ifetch_group;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_v_i;
  logic [31:0]   pc_i;
  logic          pc_ready_o;
  logic          flush_i;
  logic          icache_req_o;
  logic [31:0]   icache_adr_o;
  logic          icache_stall_i;
  logic [63:0]   icache_instr_i;
  logic [1:0]    dec_valid_o;
  logic [63:0]   dec_instr_o;
  logic [63:0]   dec_pc_o;
  logic          dec_ready_i;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;
`endif
  logic [129:0]  dec_bus;

  assign dec_bus = {dec_valid_o, dec_instr_o, dec_pc_o};

  always #5 clk = ~clk;

  ifetch_group dut (
    .clk            (clk),
    .reset          (reset),
    .pc_v_i         (pc_v_i),
    .pc_i           (pc_i),
    .pc_ready_o     (pc_ready_o),
    .flush_i        (flush_i),
    .icache_req_o   (icache_req_o),
    .icache_adr_o   (icache_adr_o),
    .icache_stall_i (icache_stall_i),
    .icache_instr_i (icache_instr_i),
    .dec_valid_o    (dec_valid_o),
    .dec_instr_o    (dec_instr_o),
    .dec_pc_o       (dec_pc_o),
    .dec_ready_i    (dec_ready_i)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_flush_cnt_o (perf_flush_cnt)
`endif
  );

  typedef struct {
    logic          pv;
    logic [31:0]   pc;
    logic          fl;
    logic          st;
    logic [63:0]   ins;
    logic          rdy;
    logic          e_rdy;
    logic          e_req;
    logic [31:0]   e_adr;
    logic [129:0]  e_dec;
  } vec_t;

  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0001;
  localparam logic [31:0] B0 = 32'h2222_0000, B1 = 32'h2222_0001;
  localparam logic [31:0] C0 = 32'h3333_0000, C1 = 32'h3333_0001;

  vec_t          vecs [8];
  logic [129:0]  exp_q [$];
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected decode bus for a group fetched from pc: lines below the offset are zero.
  function automatic logic [129:0] mk(input logic [31:0] pc, input logic [63:0] ins);
    logic [31:0] base;
    base = {pc[31:3], 3'b000};
    if (pc[2]) return {2'b10, ins[63:32], 32'h0, base + 32'd4, 32'h0};
    else       return {2'b11, ins, base + 32'd4, base};
  endfunction

  function automatic logic [63:0] dat(input int i);
    return {32'hC0DE_0000 + 32'(2 * i + 1), 32'hC0DE_0000 + 32'(2 * i)};
  endfunction

  // One cycle: drive after the edge, check at the falling edge, consume popped groups.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic fl, input logic st,
                       input logic [63:0] ins, input logic rdy,
                       input int e_rdy = -1, input int e_req = -1);
    pc_v_i = pv; pc_i = pc; flush_i = fl; icache_stall_i = st;
    icache_instr_i = ins; dec_ready_i = rdy;
    @(negedge clk);
    if (e_rdy >= 0) check("pc_ready", {191'b0, pc_ready_o}, {191'b0, e_rdy[0]});
    if (e_req >= 0) check("icache_req", {191'b0, icache_req_o}, {191'b0, e_req[0]});
    if (rdy && (|dec_valid_o)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_group: got %0h expected none", dec_bus);
      end else begin
        check("group", {62'b0, dec_bus}, {62'b0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pc_v_i = 1'b0; pc_i = '0; flush_i = 1'b0; icache_stall_i = 1'b1;
    icache_instr_i = '0; dec_ready_i = 1'b0;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 64'h0,     1'b1, 1'b1, 1'b0, 32'h0,   130'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b0, 1'b0, {A1, A0},  1'b1, 1'b1, 1'b1, 32'h100, 130'h0};
    vecs[2] = '{1'b1, 32'h104, 1'b0, 1'b1, 64'h0,     1'b1, 1'b1, 1'b0, 32'h0,
                {2'b11, A1, A0, 32'h104, 32'h100}};
    vecs[3] = '{1'b0, 32'h0,   1'b0, 1'b0, {B1, B0},  1'b1, 1'b1, 1'b1, 32'h100, 130'h0};
    vecs[4] = '{1'b0, 32'h0,   1'b0, 1'b1, 64'h0,     1'b1, 1'b1, 1'b0, 32'h0,
                {2'b10, B1, 32'h0, 32'h104, 32'h0}};
    vecs[5] = '{1'b1, 32'h208, 1'b0, 1'b1, 64'h0,     1'b1, 1'b1, 1'b0, 32'h0,   130'h0};
    vecs[6] = '{1'b1, 32'h300, 1'b1, 1'b0, {C1, C0},  1'b1, 1'b0, 1'b1, 32'h208, 130'h0};
    vecs[7] = '{1'b0, 32'h0,   1'b0, 1'b1, 64'h0,     1'b1, 1'b1, 1'b0, 32'h0,   130'h0};

    #2;
    check("reset_outputs", {27'b0, pc_ready_o, icache_req_o, icache_adr_o, dec_bus}, 192'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full-group fetch, offset fetch, and flush against a returning response.
    for (int i = 0; i < 8; i++) begin
      pc_v_i = vecs[i].pv; pc_i = vecs[i].pc; flush_i = vecs[i].fl;
      icache_stall_i = vecs[i].st; icache_instr_i = vecs[i].ins; dec_ready_i = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {28'b0, pc_ready_o, icache_req_o, icache_adr_o, dec_bus},
            {28'b0, vecs[i].e_rdy, vecs[i].e_req, vecs[i].e_adr, vecs[i].e_dec});
      @(posedge clk);
      #1;
    end

    // Fill the queue with decode stalled; one pop reopens the PC port.
    for (int i = 0; i <= 4; i++) begin
      if (i >= 1) exp_q.push_back(mk(32'h400 + 32'(8 * (i - 1)), dat(i - 1)));
      cycle(i < 4, 32'h400 + 32'(8 * i), 1'b0, 1'b0, dat(i - 1), 1'b0, (i < 4) ? 1 : 0);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b0, 0, 0);
    check("full_head_valid", {190'b0, dec_valid_o}, {190'b0, 2'b11});
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1, 0, 0);
    cycle(1'b1, 32'h420, 1'b0, 1'b1, 64'h0, 1'b0, 1, 0);
    exp_q.push_back(mk(32'h420, dat(4)));
    cycle(1'b0, 32'h0, 1'b0, 1'b0, dat(4), 1'b0, 0, 1);
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1);
    check("fill_drained", {160'b0, 32'(exp_q.size())}, 192'h0);

    // Flush while stalled: DROP swallows the late response, next fetch is clean.
    cycle(1'b1, 32'h504, 1'b0, 1'b1, 64'h0, 1'b0, 1, 0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 64'h0, 1'b0, 0, 1);
    cycle(1'b1, 32'h600, 1'b0, 1'b1, 64'h0, 1'b0, 0, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b0, 0, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, dat(9), 1'b1, 0, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1, 0);
    exp_q.push_back(mk(32'h50C, dat(10)));
    cycle(1'b1, 32'h50C, 1'b0, 1'b1, 64'h0, 1'b0, 1, 0);
    check("refetch_adr", {160'b0, icache_adr_o}, {160'b0, 32'h508});
    cycle(1'b0, 32'h0, 1'b0, 1'b0, dat(10), 1'b0, 1, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1);
    check("flush_drained", {160'b0, 32'(exp_q.size())}, 192'h0);

    // Back-to-back fetch with a pop every cycle across many pointer wraps.
    for (int i = 0; i <= 20; i++) begin
      if (i >= 1) exp_q.push_back(mk(32'h600 + 32'(4 * (i - 1)), dat(20 + i - 1)));
      cycle(i < 20, 32'h600 + 32'(4 * i), 1'b0, 1'b0, dat(20 + i - 1), 1'b1, 1);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1);
    check("stream_drained", {160'b0, 32'(exp_q.size())}, 192'h0);

    // Asynchronous reset with a group queued and a request outstanding.
    exp_q.push_back(mk(32'h700, dat(40)));
    cycle(1'b1, 32'h700, 1'b0, 1'b1, 64'h0, 1'b0, 1, 0);
    cycle(1'b1, 32'h708, 1'b0, 1'b0, dat(40), 1'b0, 1, 1);
    pc_v_i = 1'b0; flush_i = 1'b0; icache_stall_i = 1'b1; dec_ready_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", {27'b0, pc_ready_o, icache_req_o, icache_adr_o, dec_bus}, 192'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, dat(41), 1'b1, 1, 0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1, 0);
    check("post_reset_empty", {190'b0, dec_valid_o}, 192'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
